approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (4..16).
REQ-002 SHALL have parameter L, default 4, number of low x rows approximated (0..WIDTH-1).
REQ-003 SHALL have ports clk input 1 (clock) and rst_n input 1 (reset); one clock, reset is asynchronous and active-low.
REQ-004 SHALL have in_valid input 1: operand beat present.
REQ-005 SHALL have in_ready output 1: beat accepted when in_valid && in_ready.
REQ-006 SHALL have x input WIDTH: multiplier operand.
REQ-007 SHALL have y input WIDTH: multiplicand operand.
REQ-008 SHALL have mode input 1: 0 exact product, 1 approximate product.
REQ-009 SHALL have out_valid output 1: result present.
REQ-010 SHALL have out_ready input 1: result consumed when out_valid && out_ready.
REQ-011 SHALL have z output 2*WIDTH: unsigned product.
REQ-012 SHALL have z_mode output 1: mode echoed with its result.
REQ-013 SHALL have approx_cnt output 16: number of approximate results delivered.

Function
REQ-014 Exact mode SHALL give z = x*y, full 2*WIDTH bits, no truncation.
REQ-015 Approximate mode SHALL give z = ((y*x[WIDTH-1:L]) << L) + S, where S = sum over rows i<L and columns j of (y[j]&x[i]) << (i+j), including only bits with i+j >= WIDTH-1.
REQ-016 Partial-product bits of rows i<L in columns below WIDTH-1 SHALL be dropped; rows i>=L SHALL always be exact.
REQ-017 L=0 SHALL make approximate mode identical to exact mode.
REQ-018 Result width SHALL be 2*WIDTH; the approximate result never exceeds the exact one, so it SHALL never overflow.
REQ-019 The pipeline SHALL have two register stages: S1 holds the high-row product, the truncated low sum S (or the exact low sum) and mode; S2 holds the final sum z and z_mode.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid when no stall occurs.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 Each stage SHALL advance when it is empty or the next stage advances; in_ready = !S1_valid || S1 advances (combinational path from out_ready allowed).
REQ-023 While out_valid && !out_ready, z, z_mode and out_valid SHALL hold stable.
REQ-024 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-025 On an output handshake with z_mode=1, approx_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-026 An input and an output handshake in the same cycle SHALL both complete.

Reset
REQ-027 rst_n low SHALL asynchronously clear the S1/S2 valid bits, z=0, z_mode=0, approx_cnt=0; in_ready SHALL read 1 after release.
REQ-028 In-flight beats SHALL be discarded on reset mid-operation, with no spurious out_valid after release.

Structure
REQ-029 A shared package approx_mult_pkg SHALL hold the mode encodings (MODE_EXACT=0, MODE_APPROX=1) and the counter width constant 16.
REQ-030 One sub-module, approx_pp_trunc, SHALL be combinational and compute S (and the exact low sum) for given WIDTH and L; approx_mult_pipe owns all registers.

Verification (WIDTH=8, L=4)
REQ-031 mode=0, x=255, y=255 -> z=65025 two cycles later, z_mode=0, approx_cnt stays 0.
REQ-032 mode=1, x=255, y=255 -> z=64528 (61200+3328); mode=1, x=15, y=255 -> z=3328; approx_cnt=2.
REQ-033 mode=1, x=16, y=3 -> z=48, equal to exact; mode=1, x=0, y=200 -> z=0.
REQ-034 Back-to-back stream of 8 beats with out_ready low for cycles 3-5 -> no loss, order kept, in_ready drops once both stages are full, z stable while stalled.
REQ-035 rst_n asserted with 2 beats in flight -> outputs cleared immediately, no out_valid after release, approx_cnt=0.
REQ-036 Random 10k beats, both modes -> match golden model; L=0 build -> approximate results equal exact results.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier pipeline: mode encodings
// and the delivered-result counter width.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/approx_pp_trunc.sv
// Combinational low-row partial-product summation: the exact sum of rows i<L
// and the truncated sum that keeps only bits landing in columns >= WIDTH-1.
module approx_pp_trunc #(
  parameter int WIDTH = 8,
  parameter int L     = 4
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] s_trunc,
  output logic [2*WIDTH-1:0] s_exact
);

  localparam int PW = 2 * WIDTH;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path through
    // this block leaves a value unassigned, which would infer a latch.
    s_trunc = '0;
    s_exact = '0;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (x[i] && y[j]) begin
          s_exact = s_exact + (PW'(1) << (i + j));
          if (i + j >= WIDTH - 1) begin
            s_trunc = s_trunc + (PW'(1) << (i + j));
          end
        end
      end
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready unsigned multiplier with a selectable approximate mode
// that drops low-row partial-product bits below column WIDTH-1.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int L     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               z_mode,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] x_hi;
  logic [PW-1:0]    hi_prod;
  logic [PW-1:0]    s_trunc;
  logic [PW-1:0]    s_exact;
  logic [PW-1:0]    low_sel;
  logic             s2_adv;

  logic             s1_valid;
  logic [PW-1:0]    s1_hi;
  logic [PW-1:0]    s1_low;
  mode_e            s1_mode;

  approx_pp_trunc #(
    .WIDTH (WIDTH),
    .L     (L)
  ) u_pp (
    .x       (x),
    .y       (y),
    .s_trunc (s_trunc),
    .s_exact (s_exact)
  );

  // Rows i>=L are always exact: y * x[WIDTH-1:L], realigned to weight 2^L.
  assign x_hi    = x >> L;
  assign hi_prod = (PW'(y) * PW'(x_hi)) << L;
  assign low_sel = (mode == MODE_APPROX) ? s_trunc : s_exact;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // NOTE: the data registers are reset along with the valid bits so z and
  // z_mode read as zero out of reset rather than holding stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_hi      <= '0;
      s1_low     <= '0;
      s1_mode    <= MODE_EXACT;
      out_valid  <= 1'b0;
      z          <= '0;
      z_mode     <= 1'b0;
      approx_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let S2 capture the old S1 contents in
      // the same edge that S1 loads a new beat.
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_hi   <= hi_prod;
          s1_low  <= low_sel;
          s1_mode <= mode_e'(mode);
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          z      <= s1_hi + s1_low;
          z_mode <= s1_mode;
        end
      end
      if (out_valid && out_ready && (z_mode == MODE_APPROX) && (approx_cnt != '1)) begin
        approx_cnt <= approx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe (WIDTH=8): an L=4 instance checked
// against a bit-weight reference model and an L=0 instance checked against x*y.
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int LA = 4;

  typedef struct {
    logic [2*W-1:0] z;
    logic           m;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] z;
  logic           z_mode;
  logic [15:0]    approx_cnt;

  logic           in_ready0;
  logic           out_valid0;
  logic [2*W-1:0] z0;
  logic           z_mode0;
  logic [15:0]    approx_cnt0;

  exp_t           q[$];
  logic [2*W-1:0] q0[$];
  int             tests = 0;
  int             fails = 0;
  int             exp_cnt = 0;

  approx_mult_pipe #(.WIDTH(W), .L(LA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .z_mode     (z_mode),
    .approx_cnt (approx_cnt)
  );

  approx_mult_pipe #(.WIDTH(W), .L(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready0),
    .x          (x),
    .y          (y),
    .mode       (mode),
    .out_valid  (out_valid0),
    .out_ready  (out_ready),
    .z          (z0),
    .z_mode     (z_mode0),
    .approx_cnt (approx_cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: sum the weight 2^(i+j) of every set partial-product bit that the
  // chosen mode keeps (approx drops rows i<l whose column is below W-1).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m, input int l);
    int acc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (!m || i >= l || i + j >= W - 1)) acc += (1 << (i + j));
    return (2*W)'(acc);
  endfunction

  function automatic void push_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    e.z = model(a, b, m, LA);
    e.m = m;
    q.push_back(e);
    q0.push_back((2*W)'(a) * (2*W)'(b));
  endfunction

  // Present one beat until accepted, then withdraw it after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int budget = 200;
    bit done = 0;
    while (!done && budget > 0) begin
      @(negedge clk);
      in_valid = 1'b1;
      x = a;
      y = b;
      mode = m;
      #1;
      if (in_ready) begin
        push_beat(a, b, m);
        done = 1;
      end
      budget--;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 300;
    out_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #3;
      budget--;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
    #3;
  endtask

  // Monitor: pops the scoreboard on every output handshake and tracks the
  // expected approximate-result count.
  initial begin
    exp_t e;
    logic [2*W-1:0] e0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        q.delete();
        q0.delete();
        exp_cnt = 0;
      end else begin
        check("approx_cnt", 32'(approx_cnt), 32'(exp_cnt));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got z=%0d expected no result", z);
          end else begin
            e = q.pop_front();
            e0 = q0.pop_front();
            check("z", 32'(z), 32'(e.z));
            check("z_mode", 32'(z_mode), 32'(e.m));
            check("l0_valid", 32'(out_valid0), 32'd1);
            check("l0_z_exact", 32'(z0), 32'(e0));
            if (e.m && exp_cnt < 65535) exp_cnt++;
          end
        end
      end
    end
  end

  initial begin
    logic [2*W-1:0] z_hold;
    logic [W-1:0]   cx, cy;
    logic           cm;
    int             c;
    int             sent;
    bit             accepted;

    rst_n = 1'b0;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_z_mode", 32'(z_mode), 32'd0);
    check("rst_cnt", 32'(approx_cnt), 32'd0);

    // Exact 255*255 with latency check.
    send(8'd255, 8'd255, 1'b0);
    @(negedge clk);
    #3;
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #3;
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("exact_255", 32'(z), 32'd65025);
    drain();
    check("cnt_after_exact", 32'(approx_cnt), 32'd0);

    send(8'd255, 8'd255, 1'b1);
    send(8'd15, 8'd255, 1'b1);
    drain();
    check("cnt_after_two", 32'(approx_cnt), 32'd2);

    send(8'd16, 8'd3, 1'b1);
    send(8'd0, 8'd200, 1'b1);
    drain();
    check("cnt_after_four", 32'(approx_cnt), 32'd4);

    // Back-to-back stream of 8 with out_ready low for cycles 3-5.
    c = 0;
    sent = 0;
    z_hold = '0;
    cx = W'($urandom);
    cy = W'($urandom);
    cm = 1'($urandom);
    while (sent < 8 && c < 100) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid = 1'b1;
      x = cx;
      y = cy;
      mode = cm;
      #1;
      if (c == 3) z_hold = z;
      if (c == 4 || c == 5) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_z_stable", 32'(z), 32'(z_hold));
      end
      if (in_ready) begin
        push_beat(cx, cy, cm);
        sent++;
        cx = W'($urandom);
        cy = W'($urandom);
        cm = 1'($urandom);
      end
      c++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'd200, 8'd100, 1'b1);
    send(8'd17, 8'd99, 1'b1);
    @(negedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_z", 32'(z), 32'd0);
    check("midrst_cnt", 32'(approx_cnt), 32'd0);
    repeat (2) @(negedge clk);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #3;
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
    end

    // Random traffic, both modes, random backpressure.
    sent = 0;
    c = 0;
    accepted = 0;
    while (sent < 10000 && c < 60000) begin
      @(negedge clk);
      if (accepted) in_valid = 1'b0;
      accepted = 0;
      out_ready = ($urandom_range(3) != 0);
      if (!in_valid && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        case ($urandom_range(7))
          0: x = '1;
          1: x = '0;
          default: x = W'($urandom);
        endcase
        y = ($urandom_range(7) == 0) ? '1 : W'($urandom);
        mode = 1'($urandom);
      end
      #1;
      if (in_valid && in_ready) begin
        push_beat(x, y, mode);
        sent++;
        accepted = 1;
      end
      c++;
    end
    check("random_sent", 32'(sent), 32'd10000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
